// File: rtl/req_pkg.sv
// Shared types and defaults for the request encoder.
package req_pkg;

  typedef enum logic {
    MODE_PRIORITY = 1'b0,
    MODE_UNIQUE   = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned DEF_N = 8;
  localparam int unsigned DEF_W = 3;

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational lowest-index encoder with any/overlap detection.
module prio_enc_comb #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[W-1:0];
    end
  end

  assign any   = |vec;
  assign multi = ($countones(vec) > 1);

endmodule

// File: rtl/req_encoder.sv
// Sticky request capture with lowest-index grant and valid/ready handoff.
//   state | meaning
//   IDLE  | no grant held; code keeps its last value
//   HOLD  | code is a pending grant, valid=1 until accepted
module req_encoder
  import req_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned W    = DEF_W,
  parameter mode_e       MODE = MODE_PRIORITY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         multi_err,
  output logic [7:0]   grant_cnt
);

  localparam logic UNIQ = (MODE == MODE_UNIQUE);

  state_e         state, state_nxt;
  logic [N-1:0]   pnd, pnd_nxt, clr;
  logic [W-1:0]   code_nxt, sel_idx;
  logic           merr_nxt, sel_any, sel_multi, acc;
  logic [7:0]     cnt_nxt;

  // Set wins over the acceptance clear, so req is ORed in after the clear.
  always_comb begin
    acc = (state == HOLD) && ready;
    clr = '0;
    if (acc) clr[code] = 1'b1;
    pnd_nxt = (pnd & ~clr) | req;
  end

  prio_enc_comb #(.N(N), .W(W)) u_enc (
    .vec   (pnd_nxt),
    .idx   (sel_idx),
    .any   (sel_any),
    .multi (sel_multi)
  );

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    merr_nxt  = 1'b0;
    cnt_nxt   = grant_cnt;
    case (state)
      IDLE: begin
        if (sel_any) begin
          state_nxt = HOLD;
          code_nxt  = sel_idx;
          merr_nxt  = UNIQ && sel_multi;
        end
      end
      HOLD: begin
        if (acc) begin
          cnt_nxt = grant_cnt + 8'd1;
          if (sel_any) begin
            code_nxt = sel_idx;
            merr_nxt = UNIQ && sel_multi;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pnd       <= '0;
      code      <= '0;
      multi_err <= 1'b0;
      grant_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      pnd       <= pnd_nxt;
      code      <= code_nxt;
      multi_err <= merr_nxt;
      grant_cnt <= cnt_nxt;
    end
  end

  assign valid = (state == HOLD);

endmodule

// File: tb/tb_req_encoder.sv
// Directed and randomized checks of req_encoder against a queue-free set model.
module tb_req_encoder;
  import req_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       ready = 1'b0;
  logic [2:0] code_p, code_u;
  logic       valid_p, valid_u, merr_p, merr_u;
  logic [7:0] cnt_p, cnt_u;

  int checks = 0;
  int failures = 0;

  // model: set of pending indices, held grant, counter
  bit  m_pend [8];
  bit  m_hold;
  int  m_code;
  bit  m_merr;
  int  m_cnt;

  always #5 clk = ~clk;

  req_encoder #(.N(8), .W(3), .MODE(MODE_PRIORITY)) dut_p (
    .clk(clk), .rst(rst), .req(req), .code(code_p), .valid(valid_p),
    .ready(ready), .multi_err(merr_p), .grant_cnt(cnt_p)
  );

  req_encoder #(.N(8), .W(3), .MODE(MODE_UNIQUE)) dut_u (
    .clk(clk), .rst(rst), .req(req), .code(code_u), .valid(valid_u),
    .ready(ready), .multi_err(merr_u), .grant_cnt(cnt_u)
  );

  task automatic model_update(input logic [7:0] r, input logic rd, input logic rs);
    bit accepted;
    int n;
    if (rs) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_hold = 0; m_code = 0; m_merr = 0; m_cnt = 0;
      return;
    end
    accepted = m_hold && rd;
    if (accepted) begin
      m_pend[m_code] = 0;
      m_cnt = (m_cnt + 1) % 256;
    end
    for (int i = 0; i < 8; i++) if (r[i]) m_pend[i] = 1;
    m_merr = 0;
    if (!m_hold || accepted) begin
      n = 0;
      for (int i = 7; i >= 0; i--) if (m_pend[i]) begin m_code = i; n++; end
      m_hold = (n > 0);
      m_merr = (n > 1);
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic rd, input logic rs);
    req = r; ready = rd; rst = rs;
    @(posedge clk);
    model_update(r, rd, rs);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(8'hFF, 1'b1, 1'b1);
    drive(8'hFF, 1'b0, 1'b1);
    checks++; if (valid_p !== 1'b0 || valid_u !== 1'b0) begin failures++; $display("FAIL reset_valid got %b/%b want 0", valid_p, valid_u); end
    checks++; if (code_p !== 3'd0 || code_u !== 3'd0) begin failures++; $display("FAIL reset_code got %0d/%0d want 0", code_p, code_u); end
    checks++; if (cnt_p !== 8'd0 || cnt_u !== 8'd0) begin failures++; $display("FAIL reset_cnt got %0d/%0d want 0", cnt_p, cnt_u); end
    checks++; if (merr_p !== 1'b0 || merr_u !== 1'b0) begin failures++; $display("FAIL reset_merr got %b/%b want 0", merr_p, merr_u); end
    drive(8'h00, 1'b1, 1'b0);
    checks++; if (valid_p !== 1'b0) begin failures++; $display("FAIL reset_discard valid got %b want 0", valid_p); end
  endtask

  task automatic test_single();
    drive(8'h00, 1'b1, 1'b1);
    drive(8'h10, 1'b1, 1'b0);
    checks++; if (valid_p !== 1'b1 || code_p !== 3'd4) begin failures++; $display("FAIL single_grant got v=%b c=%0d want v=1 c=4", valid_p, code_p); end
    drive(8'h00, 1'b1, 1'b0);
    checks++; if (valid_p !== 1'b0 || cnt_p !== 8'd1) begin failures++; $display("FAIL single_done got v=%b cnt=%0d want v=0 cnt=1", valid_p, cnt_p); end
    drive(8'h00, 1'b1, 1'b0);
    checks++; if (code_p !== 3'd4) begin failures++; $display("FAIL idle_code_hold got %0d want 4", code_p); end
  endtask

  task automatic test_priority();
    logic [2:0] exp_codes [3];
    exp_codes[0] = 3'd1; exp_codes[1] = 3'd2; exp_codes[2] = 3'd7;
    drive(8'h00, 1'b1, 1'b1);
    drive(8'h86, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (valid_p !== 1'b1 || code_p !== exp_codes[k] || merr_p !== 1'b0) begin
        failures++; $display("FAIL priority_seq[%0d] got v=%b c=%0d e=%b want v=1 c=%0d e=0", k, valid_p, code_p, merr_p, exp_codes[k]);
      end
      drive(8'h00, 1'b1, 1'b0);
    end
    checks++; if (valid_p !== 1'b0 || cnt_p !== 8'd3) begin failures++; $display("FAIL priority_cnt got v=%b cnt=%0d want v=0 cnt=3", valid_p, cnt_p); end
  endtask

  task automatic test_unique();
    drive(8'h00, 1'b1, 1'b1);
    drive(8'h03, 1'b1, 1'b0);
    checks++; if (merr_u !== 1'b1 || code_u !== 3'd0 || merr_p !== 1'b0) begin failures++; $display("FAIL unique_first got e=%b c=%0d ep=%b want e=1 c=0 ep=0", merr_u, code_u, merr_p); end
    drive(8'h00, 1'b1, 1'b0);
    checks++; if (merr_u !== 1'b0 || code_u !== 3'd1 || valid_u !== 1'b1) begin failures++; $display("FAIL unique_second got e=%b c=%0d v=%b want e=0 c=1 v=1", merr_u, code_u, valid_u); end
    drive(8'h00, 1'b1, 1'b0);
    checks++; if (valid_u !== 1'b0 || cnt_u !== 8'd2) begin failures++; $display("FAIL unique_done got v=%b cnt=%0d want v=0 cnt=2", valid_u, cnt_u); end
  endtask

  task automatic test_backpressure();
    drive(8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(8'h01, 1'b0, 1'b0);
      checks++;
      if (valid_p !== 1'b1 || code_p !== 3'd0 || cnt_p !== 8'd0) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b c=%0d cnt=%0d want v=1 c=0 cnt=0", k, valid_p, code_p, cnt_p);
      end
    end
    drive(8'h01, 1'b1, 1'b0);
    checks++; if (cnt_p !== 8'd1 || valid_p !== 1'b1 || code_p !== 3'd0) begin failures++; $display("FAIL bp_repend got cnt=%0d v=%b c=%0d want cnt=1 v=1 c=0", cnt_p, valid_p, code_p); end
    drive(8'h00, 1'b1, 1'b0);
    checks++; if (cnt_p !== 8'd2 || valid_p !== 1'b0) begin failures++; $display("FAIL bp_drain got cnt=%0d v=%b want cnt=2 v=0", cnt_p, valid_p); end
    drive(8'h01, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b0);
    checks++; if (cnt_p !== 8'd3 || valid_p !== 1'b0) begin failures++; $display("FAIL bp_no_repend got cnt=%0d v=%b want cnt=3 v=0", cnt_p, valid_p); end
  endtask

  task automatic test_no_preempt();
    drive(8'h00, 1'b1, 1'b1);
    drive(8'h80, 1'b0, 1'b0);
    drive(8'h01, 1'b0, 1'b0);
    checks++; if (code_p !== 3'd7 || valid_p !== 1'b1) begin failures++; $display("FAIL no_preempt got c=%0d v=%b want c=7 v=1", code_p, valid_p); end
    drive(8'h00, 1'b1, 1'b0);
    checks++; if (code_p !== 3'd0 || valid_p !== 1'b1) begin failures++; $display("FAIL preempt_next got c=%0d v=%b want c=0 v=1", code_p, valid_p); end
  endtask

  task automatic test_reset_mid_hold();
    drive(8'h00, 1'b1, 1'b1);
    drive(8'hFF, 1'b0, 1'b0);
    drive(8'hFF, 1'b0, 1'b0);
    drive(8'hFF, 1'b1, 1'b1);
    checks++; if (valid_p !== 1'b0 || cnt_p !== 8'd0) begin failures++; $display("FAIL rst_mid got v=%b cnt=%0d want v=0 cnt=0", valid_p, cnt_p); end
    for (int k = 0; k < 4; k++) drive(8'h00, 1'b1, 1'b0);
    checks++; if (valid_p !== 1'b0 || cnt_p !== 8'd0) begin failures++; $display("FAIL rst_mid_after got v=%b cnt=%0d want v=0 cnt=0", valid_p, cnt_p); end
  endtask

  task automatic test_wrap();
    drive(8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 256; k++) drive(8'hFF, 1'b1, 1'b0);
    checks++; if (cnt_p !== 8'd255) begin failures++; $display("FAIL wrap_255 got %0d want 255", cnt_p); end
    drive(8'hFF, 1'b1, 1'b0);
    checks++; if (cnt_p !== 8'd0 || valid_p !== 1'b1) begin failures++; $display("FAIL wrap_0 got cnt=%0d v=%b want cnt=0 v=1", cnt_p, valid_p); end
  endtask

  task automatic test_random();
    logic [7:0] r;
    int errs = 0;
    drive(8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 600; k++) begin
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      drive(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0));
      checks++;
      if (valid_p !== m_hold || cnt_p !== 8'(m_cnt) || code_p !== 3'(m_code) || merr_p !== 1'b0 ||
          valid_u !== m_hold || cnt_u !== 8'(m_cnt) || code_u !== 3'(m_code) || merr_u !== m_merr) begin
        failures++; errs++;
        if (errs < 10)
          $display("FAIL random[%0d] got v=%b c=%0d cnt=%0d ep=%b eu=%b want v=%b c=%0d cnt=%0d ep=0 eu=%b",
                   k, valid_u, code_u, cnt_u, merr_p, merr_u, m_hold, m_code, m_cnt, m_merr);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_unique();
    test_backpressure();
    test_no_preempt();
    test_reset_mid_hold();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_encoder.md
REQ_ENCODER -- requirements
Module: req_encoder

Interface
REQ-001 Parameter N, default 8: number of request lines.
REQ-002 Parameter W, default 3: code width, equal to clog2(N).
REQ-003 Parameter MODE, default MODE_PRIORITY: MODE_PRIORITY means lowest index wins silently; MODE_UNIQUE means lowest index wins and overlap is flagged.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  N  request lines, sampled every cycle.
REQ-007 code  output  W  encoded index of the granted request.
REQ-008 valid  output  1  code holds a pending grant.
REQ-009 ready  input  1  consumer accepts code when valid and ready.
REQ-010 multi_err  output  1  one-cycle pulse flagging a unique-mode overlap at selection.
REQ-011 grant_cnt  output  8  count of accepted grants; wraps.

Function
REQ-012 Pending register pnd[N-1:0] SHALL OR in req every cycle (sticky capture).
REQ-013 FSM SHALL have two states, IDLE and HOLD.
REQ-014 IDLE: valid=0; when pnd|req is nonzero, load code with the lowest set index of (pnd|req) and go to HOLD next cycle.
REQ-015 HOLD: valid=1; code and valid SHALL stay stable until valid&&ready.
REQ-016 On valid&&ready, the pnd bit at index code SHALL clear, grant_cnt SHALL increment, and the FSM SHALL re-select in the same cycle.
REQ-017 Re-select: if remaining pnd|req is nonzero, stay in HOLD with the new code next cycle (back-to-back, one grant per cycle); otherwise go to IDLE.
REQ-018 Latency: a request on an idle block SHALL produce valid one cycle after it is sampled.
REQ-019 Set/clear collision: a req bit asserted in the same cycle its pnd bit is cleared by acceptance SHALL remain pending (set wins).
REQ-020 Selection SHALL occur only at the IDLE load or at acceptance; a higher-priority request arriving during HOLD SHALL NOT preempt the held code.
REQ-021 MODE_UNIQUE: multi_err SHALL pulse for one cycle, registered with the new code, when more than one bit of the selected vector is set; it SHALL stay 0 in MODE_PRIORITY.
REQ-022 grant_cnt SHALL wrap from 255 to 0 with no flag.
REQ-023 code SHALL hold its last value while in IDLE.

Reset
REQ-024 While rst=1: pnd=0, state=IDLE, code=0, valid=0, multi_err=0, grant_cnt=0.
REQ-025 Reset asserted mid-HOLD SHALL drop all pending and held grants; no acceptance is counted in the reset cycle.
REQ-026 req sampled during rst=1 SHALL be discarded.

Structure
REQ-027 Shared package req_pkg SHALL hold the mode enum (MODE_PRIORITY, MODE_UNIQUE), the FSM state enum, and the default N and W constants.
REQ-028 Combinational lowest-index encoder with popcount>1 detect SHALL live in sub-module prio_enc_comb, with inputs vec[N-1:0] and outputs idx[W-1:0], any, multi.
REQ-029 The top module SHALL hold the pnd register, the FSM, the output registers, and the counter.

Verification
REQ-030 Single request: after reset, req=8'h10 for one cycle with ready=1 -> valid=1, code=4 on the next cycle; then IDLE; grant_cnt=1.
REQ-031 Priority order: req=8'h86 for one cycle with ready=1 -> codes 1, 2, 7 on three consecutive cycles; grant_cnt=3; multi_err=0 in MODE_PRIORITY.
REQ-032 Unique overlap: MODE_UNIQUE, req=8'h03 -> multi_err pulses once with code=0; the second grant, code=1, has multi_err=0.
REQ-033 Backpressure: ready=0 for 5 cycles while req=8'h01 -> code=0 held stable, grant_cnt unchanged; then ready=1 -> one acceptance, and pnd bit 0 re-pends only if req is still high (set wins).
REQ-034 Reset mid-HOLD: req=8'hFF, ready=0, rst=1 for one cycle -> valid=0 and grant_cnt=0 next cycle; with req=0, no further grants.
REQ-035 Wrap: 256 acceptances -> grant_cnt=0.
